// File: rtl/dwt_pkg.sv
// Shared state encoding and parameter defaults for the DWT frame sequencer.
package dwt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } seq_state_e;

  localparam int DWT_DATA_W_DEF   = 8;
  localparam int DWT_CORE_LAT_DEF = 4;

endpackage

// File: rtl/dwt_ext_hist.sv
// History of the most recent frame samples, read back in mirrored order
// to build the symmetric-extension tail.
module dwt_ext_hist #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 5,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic [IDX_W-1:0]  tail_idx,
  output logic [DATA_W-1:0] tail_data
);

  logic [DEPTH-1:0][DATA_W-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clr) begin
      hist_d = '0;
    end else if (push) begin
      hist_d = {hist_q[DEPTH-2:0], din};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  // Entry 0 is the last frame sample; tail sample i mirrors around it, so it is entry i+1.
  always_comb begin
    tail_data = '0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      if (int'(tail_idx) == j) begin
        tail_data = hist_q[j+1];
      end
    end
  end

endmodule

// File: rtl/dwt_frame_sequencer.sv
// Frame controller for the 2-level 1-D DWT core: gates, clears and flushes the core
// and frames its outputs. Define DWT_SEQ_SYMEXT_EN for a symmetric-extension tail.
module dwt_frame_sequencer
  import dwt_pkg::*;
#(
  parameter int DATA_W   = DWT_DATA_W_DEF,
  parameter int CORE_LAT = DWT_CORE_LAT_DEF,
  parameter int LEN_W    = 6
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] core_data,
  output logic              core_en,
  output logic              core_clr,
  input  logic [DATA_W-1:0] core_high,
  input  logic [DATA_W-1:0] core_low,
  output logic [DATA_W-1:0] m_high,
  output logic [DATA_W-1:0] m_low,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int   EN_W    = LEN_W + 1;
  localparam int   FL_W    = $clog2(CORE_LAT + 1);
  localparam logic LAT_ODD = (CORE_LAT % 2) == 1;

  seq_state_e        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  in_cnt_q, in_cnt_d;
  logic [LEN_W-1:0]  out_cnt_q, out_cnt_d;
  logic [FL_W-1:0]   fl_cnt_q, fl_cnt_d;
  logic [EN_W-1:0]   en_cnt_q, en_cnt_d;
  logic [DATA_W-1:0] m_high_q, m_high_d;
  logic [DATA_W-1:0] m_low_q, m_low_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] tail_data;
  logic              stall, len_ok, capture;

  assign stall = m_valid_q & ~m_ready;

`ifdef DWT_SEQ_SYMEXT_EN
  logic hist_push;
  assign hist_push = (state_q == FEED) && s_valid && !stall;

  dwt_ext_hist #(
    .DATA_W (DATA_W),
    .DEPTH  (CORE_LAT + 1),
    .IDX_W  (FL_W)
  ) u_hist (
    .clk       (sys_clk),
    .rst_n     (sys_rst),
    .clr       (core_clr),
    .push      (hist_push),
    .din       (s_data),
    .tail_idx  (fl_cnt_q),
    .tail_data (tail_data)
  );

  // The mirrored tail reaches back CORE_LAT samples before the last one.
  assign len_ok = !cfg_len[0] && (cfg_len >= LEN_W'(4)) && (cfg_len >= LEN_W'(CORE_LAT + 2));
`else
  assign tail_data = '0;
  assign len_ok    = !cfg_len[0] && (cfg_len >= LEN_W'(4));
`endif

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    fl_cnt_d  = fl_cnt_q;
    en_cnt_d  = en_cnt_q;
    err_d     = 1'b0;
    s_ready   = 1'b0;
    core_en   = 1'b0;
    core_data = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d     = cfg_len;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            fl_cnt_d  = '0;
            en_cnt_d  = '0;
            state_d   = CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: state_d = FEED;
      FEED: begin
        s_ready = ~stall;
        core_en = s_valid & ~stall;
        if (core_en) begin
          core_data = s_data;
          in_cnt_d  = in_cnt_q + LEN_W'(1);
          if (in_cnt_q == len_q - LEN_W'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        core_en = ~stall;
        if (core_en) begin
          core_data = tail_data;
          fl_cnt_d  = fl_cnt_q + FL_W'(1);
          if (fl_cnt_q == FL_W'(CORE_LAT - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!m_valid_q || m_ready) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (core_en) begin
      en_cnt_d = en_cnt_q + EN_W'(1);
    end

    // Every second enabled cycle after the pipeline fill carries a fresh high/low pair.
    capture = core_en && (en_cnt_q >= EN_W'(CORE_LAT)) && (en_cnt_q[0] == LAT_ODD);

    m_valid_d = capture | stall;
    m_high_d  = m_high_q;
    m_low_d   = m_low_q;
    m_last_d  = m_valid_d ? m_last_q : 1'b0;
    if (capture) begin
      m_high_d  = core_high;
      m_low_d   = core_low;
      m_last_d  = (out_cnt_q == (len_q >> 1) - LEN_W'(1));
      out_cnt_d = out_cnt_q + LEN_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state_q   <= IDLE;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      fl_cnt_q  <= '0;
      en_cnt_q  <= '0;
      m_high_q  <= '0;
      m_low_q   <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      fl_cnt_q  <= fl_cnt_d;
      en_cnt_q  <= en_cnt_d;
      m_high_q  <= m_high_d;
      m_low_q   <= m_low_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      err_q     <= err_d;
    end
  end

  assign core_clr = (state_q == CLEAR);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign m_high   = m_high_q;
  assign m_low    = m_low_q;
  assign m_valid  = m_valid_q;
  assign m_last   = m_last_q;

endmodule

// File: tb/tb_dwt_frame_sequencer.sv
// Directed bench for dwt_frame_sequencer with a delay-line stand-in for the DWT core.
module tb_dwt_frame_sequencer;
  localparam int DATA_W   = 8;
  localparam int CORE_LAT = 4;
  localparam int LEN_W    = 6;

  logic              sys_clk = 1'b0;
  logic              sys_rst, start, s_valid, s_ready, core_en, core_clr;
  logic              m_valid, m_last, m_ready, busy, done, err;
  logic [LEN_W-1:0]  cfg_len;
  logic [DATA_W-1:0] s_data, core_data, core_high, core_low, m_high, m_low;
  logic [CORE_LAT-1:0][DATA_W-1:0] core_pipe = '0;
  logic [31:0]       out_vec;

  int n_cmp = 0;
  int n_bad = 0;
  int n_pairs, n_acc, n_en, en_bad, stall_cyc, stall_bad;
  int first_mv, last_acc, done_cyc, done_cnt, s_ready_first, n_tail;
  logic [DATA_W-1:0] got_high [8];
  logic [DATA_W-1:0] got_low  [8];
  logic              got_last [8];
  logic [DATA_W-1:0] tail_seen [CORE_LAT];

  always #5 sys_clk = ~sys_clk;

  dwt_frame_sequencer #(
    .DATA_W   (DATA_W),
    .CORE_LAT (CORE_LAT),
    .LEN_W    (LEN_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .core_data (core_data),
    .core_en   (core_en),
    .core_clr  (core_clr),
    .core_high (core_high),
    .core_low  (core_low),
    .m_high    (m_high),
    .m_low     (m_low),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  // Core stand-in: a CORE_LAT-deep delay line, so pair k is (sample 2k+1, sample 2k).
  always @(posedge sys_clk) begin
    if (core_clr) core_pipe <= '0;
    else if (core_en) core_pipe <= {core_pipe[CORE_LAT-2:0], core_data};
  end
  assign core_low  = core_pipe[CORE_LAT-1];
  assign core_high = core_pipe[CORE_LAT-2];

  assign out_vec = {s_ready, core_en, core_clr, m_valid, m_last, busy, done, err,
                    m_high, m_low, core_data};

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one frame: start, feed len samples from base, optional s_valid gaps and
  // an m_ready stall of stall_len cycles beginning at the first m_valid.
  task automatic applyStimulus(input int len, input int base, input bit gaps, input int stall_len);
    int idx;
    int stall_left;
    logic [DATA_W-1:0] held_h, held_l;
    idx = 0; stall_left = stall_len; held_h = '0; held_l = '0;
    n_pairs = 0; n_en = 0; en_bad = 0; stall_cyc = 0; stall_bad = 0; n_tail = 0;
    first_mv = -1; last_acc = -1; done_cyc = -1; done_cnt = 0; s_ready_first = 0;
    @(negedge sys_clk);
    start = 1'b1; cfg_len = LEN_W'(len);
    @(negedge sys_clk);
    start = 1'b0;
    #1 checkOutput("clear_pulse", 32'({core_clr, core_en, s_ready}), 32'b100);
    for (int cyc = 0; cyc < 300 && done_cyc < 0; cyc++) begin
      @(negedge sys_clk);
      s_valid = (idx < len) && (!gaps || (cyc % 2 == 0));
      s_data  = DATA_W'(base + idx);
      m_ready = 1'b1;
      if (m_valid && stall_left > 0) begin
        m_ready = 1'b0;
        stall_left--;
      end
      #1;
      if (cyc == 0) s_ready_first = int'(s_ready);
      if (m_valid && first_mv < 0) first_mv = cyc;
      if (core_en) n_en++;
      if (!core_en && core_data !== '0) en_bad++;
      if (idx < len && core_en !== (s_valid && s_ready)) en_bad++;
      if (idx < len && core_en && core_data !== s_data) en_bad++;
      if (idx >= len && core_en && n_tail < CORE_LAT) begin
        tail_seen[n_tail] = core_data;
        n_tail++;
      end
      if (m_valid && !m_ready) begin
        stall_cyc++;
        if (s_ready || core_en) stall_bad++;
        if (stall_cyc > 1 && (m_high !== held_h || m_low !== held_l)) stall_bad++;
        held_h = m_high; held_l = m_low;
      end
      if (s_valid && s_ready) idx++;
      if (m_valid && m_ready) begin
        if (n_pairs < 8) begin
          got_high[n_pairs] = m_high;
          got_low[n_pairs]  = m_low;
          got_last[n_pairs] = m_last;
        end
        n_pairs++;
        if (m_last) last_acc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
    end
    n_acc = idx;
    s_valid = 1'b0;
    m_ready = 1'b1;
    @(negedge sys_clk);
    #1 checkOutput("done_then_idle", 32'({done, busy}), 32'b00);
  endtask

  task automatic checkFrame(input string name, input int len, input int base);
    checkOutput({name, "_accepted"}, 32'(n_acc), 32'(len));
    checkOutput({name, "_pairs"}, 32'(n_pairs), 32'(len / 2));
    for (int k = 0; k < len / 2 && k < 8; k++) begin
      checkOutput($sformatf("%s_high%0d", name, k), 32'(got_high[k]), 32'(base + 2 * k + 1));
      checkOutput($sformatf("%s_low%0d", name, k), 32'(got_low[k]), 32'(base + 2 * k));
      checkOutput($sformatf("%s_last%0d", name, k), 32'(got_last[k]), 32'(k == len / 2 - 1));
    end
    checkOutput({name, "_en_cycles"}, 32'(n_en), 32'(len + CORE_LAT));
    checkOutput({name, "_en_rules"}, 32'(en_bad), 32'd0);
    checkOutput({name, "_done_count"}, 32'(done_cnt), 32'd1);
    checkOutput({name, "_done_lat"}, 32'(done_cyc - last_acc), 32'd2);
    checkOutput({name, "_tail_count"}, 32'(n_tail), 32'(CORE_LAT));
    for (int i = 0; i < CORE_LAT; i++) begin
`ifdef DWT_SEQ_SYMEXT_EN
      checkOutput($sformatf("%s_tail%0d", name, i), 32'(tail_seen[i]), 32'(base + len - 2 - i));
`else
      checkOutput($sformatf("%s_tail%0d", name, i), 32'(tail_seen[i]), 32'd0);
`endif
    end
  endtask

  task automatic rejectStart(input string name, input int len);
    @(negedge sys_clk);
    start = 1'b1; cfg_len = LEN_W'(len);
    @(negedge sys_clk);
    start = 1'b0;
    #1 checkOutput({name, "_err"}, 32'({err, busy}), 32'b10);
    @(negedge sys_clk);
    #1 checkOutput({name, "_err_pulse"}, 32'({err, busy}), 32'b00);
  endtask

  initial begin
    sys_rst = 1'b0; start = 1'b0; cfg_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    repeat (2) @(negedge sys_clk);
    #1 checkOutput("reset_state", out_vec, 32'd0);
    sys_rst = 1'b1;

    applyStimulus(8, 'h10, 1'b0, 0);
    checkFrame("full", 8, 'h10);
    checkOutput("full_first_sready", 32'(s_ready_first), 32'd1);
    checkOutput("full_first_mvalid", 32'(first_mv), 32'(CORE_LAT + 1));
    checkOutput("full_last_pair", 32'(last_acc), 32'(8 + CORE_LAT - 1));

    rejectStart("len5", 5);
    rejectStart("len2", 2);
`ifdef DWT_SEQ_SYMEXT_EN
    rejectStart("len4_short", 4);
`endif

    applyStimulus(8, 'h20, 1'b0, 5);
    checkFrame("stall", 8, 'h20);
    checkOutput("stall_cycles", 32'(stall_cyc), 32'd5);
    checkOutput("stall_frozen", 32'(stall_bad), 32'd0);

    applyStimulus(8, 'h10, 1'b1, 0);
    checkFrame("gaps", 8, 'h10);

    @(negedge sys_clk);
    start = 1'b1; cfg_len = LEN_W'(8);
    @(negedge sys_clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      s_valid = 1'b1; s_data = DATA_W'(8'h30 + i);
    end
    @(negedge sys_clk);
    #1 checkOutput("mid_feed_busy", 32'(busy), 32'd1);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    #1 checkOutput("mid_feed_reset", out_vec, 32'd0);
    sys_rst = 1'b1; s_valid = 1'b0;

    applyStimulus(8, 'h40, 1'b0, 0);
    checkFrame("after_reset", 8, 'h40);

`ifdef DWT_SEQ_SYMEXT_EN
    applyStimulus(8, 1, 1'b0, 0);
    checkFrame("symext", 8, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dwt_frame_sequencer.md
# dwt_frame_sequencer

Frame-level controller for the 2-level 1-D DWT core. It accepts a sample stream with valid/ready, gates the core with a clock enable, and clears the core between frames. After the last sample it flushes the core pipeline with `CORE_LAT` tail samples. It also qualifies the core's free-running `high`/`low` outputs into a framed, back-pressurable output stream. It sits between the sample source (memory reader / ADC FIFO) and the coefficient consumer.

## Interface
Parameters:
- `DATA_W`, 8, sample and coefficient width
- `CORE_LAT`, 4, enabled cycles from first sample into core to first valid core output
- `LEN_W`, 6, width of `cfg_len`; max frame length 2^LEN_W-2

Ports:
- `sys_clk`  in  1  clock, all logic on rising edge
- `sys_rst`  in  1  reset, synchronous, active-low
- `start`  in  1  single-cycle frame start request
- `cfg_len`  in  LEN_W  frame length in samples, sampled when `start` is accepted
- `s_data`  in  DATA_W  input sample
- `s_valid`  in  1  input sample valid
- `s_ready`  out  1  sequencer accepts `s_data` this cycle
- `core_data`  out  DATA_W  to core `data_in`
- `core_en`  out  1  core clock enable, one sample per enabled cycle
- `core_clr`  out  1  core state clear
- `core_high`  in  DATA_W  core `high_o`
- `core_low`  in  DATA_W  core `low_o`
- `m_high`, `m_low`  out  DATA_W  registered coefficient pair
- `m_valid`  out  1  coefficient pair valid
- `m_last`  out  1  last pair of frame, qualified by `m_valid`
- `m_ready`  in  1  consumer accepts pair
- `busy`  out  1  high in any state but IDLE
- `done`  out  1  one-cycle pulse at frame end
- `err`  out  1  one-cycle pulse on rejected `start`

## Operation
- States:
  - IDLE: waits for `start`.
  - CLEAR: one cycle, `core_clr`=1, `core_en`=0.
  - FEED: feeds input samples.
  - FLUSH: feeds tail samples.
  - DRAIN: waits until `m_valid` is low or accepted.
  - DONE: one cycle, `done`=1, then IDLE.
- `start` in IDLE:
  - `cfg_len` even and >=4: latch length, go to CLEAR.
  - Otherwise: pulse `err`, stay IDLE.
- `start` outside IDLE is ignored; no `err`.
- `stall = m_valid & ~m_ready`.
- FEED:
  - `s_ready = ~stall`.
  - `core_en = s_valid & s_ready`.
  - `core_data = s_data`.
  - `in_cnt` increments per accepted sample; the accept with `in_cnt == len-1` moves to FLUSH.
- FLUSH:
  - `core_en = ~stall`.
  - `core_data = 0`.
  - `fl_cnt` counts to `CORE_LAT`, then move to DRAIN.
- `en_cnt` counts enabled cycles from 0 within a frame.
- Output capture condition: an enabled cycle with `en_cnt >= CORE_LAT` and `(en_cnt-CORE_LAT)` even.
  - On such a cycle, the next edge loads `m_high`/`m_low` from `core_high`/`core_low` and sets `m_valid`.
  - This gives exactly `len/2` pairs per frame.
- `m_last` is set with the pair whose `out_cnt == len/2-1`.
- `m_valid` holds, with data stable, until `m_ready`; then it clears unless a new capture occurs on the same edge.
- `core_data` is 0 when `core_en`=0.

## Timing
- Reset (`sys_rst`=0 at edge), from any state including mid-frame:
  - state=IDLE, all counters 0.
  - `s_ready`, `core_en`, `core_clr`, `m_valid`, `m_last`, `busy`, `done`, `err` = 0.
  - `m_high`, `m_low`, `core_data` = 0.
  - Partial frame discarded.
- `start` to first `s_ready`: 2 cycles (IDLE→CLEAR→FEED).
- Unstalled full-rate frame, edge 0 = start accepted:
  - First `m_valid` at edge 2+CORE_LAT+1.
  - Last pair at edge 2+len+CORE_LAT-1.
  - `done` one cycle after the last pair is accepted.
- Stall freezes every counter and `core_en`. No sample is lost or duplicated.
- `s_valid` gaps in FEED only lengthen the frame.

## Configuration
- `DWT_SEQ_SYMEXT_EN`
  - Defined: FLUSH feeds a symmetric extension instead of zeros. Tail sample i is the sample at frame position len-2-i. This needs a CORE_LAT+1 deep history of the last accepted samples. It also requires `cfg_len >= CORE_LAT+2`; otherwise the `start` pulses `err`.
  - Undefined: zero tail, no history storage.

## Structure
- Package `dwt_pkg`:
  - state enum (IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE)
  - `DATA_W` default
  - `CORE_LAT` default
- Sub-module `dwt_ext_hist`: shift-register history plus mirrored read index. Instantiated only under `DWT_SEQ_SYMEXT_EN`.

## Test plan
- Reset low 2 cycles, then start with `cfg_len`=8 and samples 0x10..0x17 at full rate, `m_ready`=1 → 4 pairs, `m_last` on 4th, `done` one cycle after the 4th pair.
- `cfg_len`=5 and `cfg_len`=2 → `err` pulse each, `busy` stays 0.
- `cfg_len`=8, `m_ready` low for 5 cycles after first `m_valid` → `s_ready`/`core_en` low during the stall, `m_high`/`m_low` stable, total pairs still 4.
- `s_valid` toggling 1-0-1-0 → `core_en` only on accepted cycles, output identical to the full-rate run.
- `sys_rst` low mid-FEED (after 3 samples) → next cycle all outputs 0; new start with length 8 produces a clean 4-pair frame.
- With `DWT_SEQ_SYMEXT_EN` and len 8, samples 1..8 → `core_data` in FLUSH = 7,6,5,4.
